// File: rtl/bus_pkg.sv
// Shared definitions for the CPU/DMA bus arbiter: FSM state encoding and
// default timing parameters.
package bus_pkg;

    typedef enum logic [2:0] {
        ARB_RST    = 3'd0,
        ARB_RUN    = 3'd1,
        ARB_DMA    = 3'd2,
        ARB_RESYNC = 3'd3,
        ARB_HALT   = 3'd4
    } arb_state_e;

    localparam int RESET_CYCLES_DEF = 4;
    localparam int DMA_BURST_DEF    = 16;
    localparam int CPU_MIN_DEF      = 4;

endpackage

// File: rtl/bus_mux.sv
// RAM port source selector: DMA requester or 6502 core. Core writes are
// only let through when the arbiter says the core actually owns the cycle.
module bus_mux (
    input  logic        sel_dma,
    input  logic        cpu_we_en,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we
);

    always_comb begin
        if (sel_dma) begin
            mem_address = dma_address;
            mem_wdata   = dma_wdata;
            mem_we      = dma_we;
        end else begin
            mem_address = cpu_address;
            mem_wdata   = cpu_out;
            mem_we      = cpu_we & cpu_we_en;
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbiter for the RAM shared by the 6502 core and a DMA requester; also
// sequences core reset, DMA stalls and debugger halt/single-step.
module cpu_bus_arbiter
    import bus_pkg::*;
#(
    parameter int RESET_CYCLES = RESET_CYCLES_DEF,
    parameter int DMA_BURST    = DMA_BURST_DEF,
    parameter int CPU_MIN      = CPU_MIN_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        cpu_hold,
    output logic        cpu_reset_n,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_we,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    input  logic        halt,
    input  logic        step,
    output logic        halted
);

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int CW = $clog2(CPU_MIN + 1);
    localparam int BW = $clog2(DMA_BURST + 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CPU_SAT    = CW'(CPU_MIN);
    localparam logic [BW-1:0] BURST_LAST = BW'(DMA_BURST - 1);

    arb_state_e    state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          step_flag_q, step_flag_d;
    logic          dma_rvalid_q, dma_rvalid_d;
    logic          sel_dma, cpu_we_en;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ARB_RST;
            rst_cnt_q    <= '0;
            cpu_cnt_q    <= CPU_SAT;
            burst_cnt_q  <= '0;
            step_flag_q  <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cpu_cnt_q    <= cpu_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            step_flag_q  <= step_flag_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cpu_cnt_d    = cpu_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        step_flag_d  = step_flag_q;
        dma_rvalid_d = dma_ack & ~dma_we;
        case (state_q)
            ARB_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = ARB_RUN;
                else                       rst_cnt_d = rst_cnt_q + RW'(1);
            end
            ARB_RUN: begin
                if (cpu_cnt_q < CPU_SAT) cpu_cnt_d = cpu_cnt_q + CW'(1);
                // Only a read cycle may end RUN so a core write is never split.
                if (!cpu_we) begin
                    if (halt || step_flag_q) begin
                        state_d     = ARB_HALT;
                        step_flag_d = 1'b0;
                    end else if (dma_req && cpu_cnt_q >= CPU_SAT) begin
                        state_d = ARB_DMA;
                    end
                end
            end
            ARB_DMA: begin
                if (burst_cnt_q < BURST_LAST) burst_cnt_d = burst_cnt_q + BW'(1);
                if (!dma_req || (!halt && burst_cnt_q >= BURST_LAST)) begin
                    state_d     = halt ? ARB_HALT : ARB_RESYNC;
                    burst_cnt_d = '0;
                    cpu_cnt_d   = '0;
                end
            end
            ARB_RESYNC: state_d = ARB_RUN;
            ARB_HALT: begin
                if (dma_req) begin
                    state_d = ARB_DMA;
                end else if (!halt) begin
                    state_d     = ARB_RESYNC;
                    step_flag_d = 1'b0;
                end else if (step) begin
                    state_d     = ARB_RESYNC;
                    step_flag_d = 1'b1;
                end
            end
            default: state_d = ARB_RST;
        endcase
    end

    always_comb begin
        cpu_hold    = 1'b0;
        cpu_reset_n = 1'b1;
        dma_ack     = 1'b0;
        halted      = 1'b0;
        sel_dma     = 1'b0;
        cpu_we_en   = 1'b0;
        case (state_q)
            ARB_RST: begin
                cpu_hold    = 1'b1;
                cpu_reset_n = 1'b0;
            end
            ARB_RUN: begin
                cpu_hold  = 1'b1;
                cpu_we_en = 1'b1;
            end
            ARB_DMA: begin
                sel_dma = 1'b1;
                dma_ack = 1'b1;
            end
            ARB_RESYNC: ;
            ARB_HALT: halted = 1'b1;
            default: begin
                cpu_hold    = 1'b1;
                cpu_reset_n = 1'b0;
            end
        endcase
    end

    bus_mux u_bus_mux (
        .sel_dma     (sel_dma),
        .cpu_we_en   (cpu_we_en),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_we      (dma_we),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we)
    );

    assign cpu_in     = mem_rdata;
    assign dma_rdata  = mem_rdata;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: bus-ownership reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cpu_bus_arbiter;

    localparam int RESET_CYCLES = 4;
    localparam int DMA_BURST    = 16;
    localparam int CPU_MIN      = 4;
    localparam int M_BOOT = 0, M_CORE = 1, M_DMA = 2, M_GAP = 3, M_STOP = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_out = '0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_in;
    logic        cpu_hold, cpu_reset_n;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_req = 1'b0;
    logic [15:0] dma_address = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_we = 1'b0;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_rvalid;
    logic        halt = 1'b0;
    logic        step = 1'b0;
    logic        halted;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    always #5 clock = ~clock;

    cpu_bus_arbiter #(
        .RESET_CYCLES (RESET_CYCLES),
        .DMA_BURST    (DMA_BURST),
        .CPU_MIN      (CPU_MIN)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_we      (cpu_we),
        .cpu_in      (cpu_in),
        .cpu_hold    (cpu_hold),
        .cpu_reset_n (cpu_reset_n),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .dma_req     (dma_req),
        .dma_address (dma_address),
        .dma_wdata   (dma_wdata),
        .dma_we      (dma_we),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .dma_rvalid  (dma_rvalid),
        .halt        (halt),
        .step        (step),
        .halted      (halted)
    );

    // Synchronous RAM with one cycle of read latency.
    logic [7:0] ram [0:65535];
    logic [7:0] ram_q = '0;
    always @(posedge clock) begin
        if (mem_we) ram[mem_address] <= mem_wdata;
        ram_q <= ram[mem_address];
    end
    assign mem_rdata = ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, counted in plain integers.
    int m_mode, m_rst_left, m_since, m_burst;
    bit m_step, m_rvalid;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode     <= M_BOOT;
            m_rst_left <= RESET_CYCLES;
            m_since    <= CPU_MIN;
            m_burst    <= 0;
            m_step     <= 1'b0;
            m_rvalid   <= 1'b0;
        end else begin
            m_rvalid <= (m_mode == M_DMA) && !dma_we;
            case (m_mode)
                M_BOOT: begin
                    m_rst_left <= m_rst_left - 1;
                    if (m_rst_left <= 1) m_mode <= M_CORE;
                end
                M_CORE: begin
                    m_since <= m_since + 1;
                    if (!cpu_we) begin
                        if (halt || m_step) begin
                            m_mode <= M_STOP;
                            m_step <= 1'b0;
                        end else if (dma_req && m_since >= CPU_MIN) begin
                            m_mode <= M_DMA;
                        end
                    end
                end
                M_DMA: begin
                    if (!dma_req || (!halt && m_burst + 1 >= DMA_BURST)) begin
                        m_mode  <= halt ? M_STOP : M_GAP;
                        m_burst <= 0;
                        m_since <= 0;
                    end else begin
                        m_burst <= m_burst + 1;
                    end
                end
                M_GAP: m_mode <= M_CORE;
                default: begin
                    if (dma_req) m_mode <= M_DMA;
                    else if (!halt) begin
                        m_mode <= M_GAP;
                        m_step <= 1'b0;
                    end else if (step) begin
                        m_mode <= M_GAP;
                        m_step <= 1'b1;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin : cmp
        logic e_hold, e_rstn, e_ack, e_halted, e_we, chk_addr;
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        if (armed) begin
            e_hold = 1'b0; e_rstn = 1'b1; e_ack = 1'b0; e_halted = 1'b0;
            e_we = 1'b0; chk_addr = 1'b1; e_addr = cpu_address; e_wdata = cpu_out;
            case (m_mode)
                M_BOOT: begin e_hold = 1'b1; e_rstn = 1'b0; chk_addr = 1'b0; end
                M_CORE: begin e_hold = 1'b1; e_we = cpu_we; end
                M_DMA:  begin e_ack = 1'b1; e_addr = dma_address; e_we = dma_we; e_wdata = dma_wdata; end
                M_GAP:  ;
                default: e_halted = 1'b1;
            endcase
            chk("cpu_hold", cpu_hold, e_hold);
            chk("cpu_reset_n", cpu_reset_n, e_rstn);
            chk("dma_ack", dma_ack, e_ack);
            chk("halted", halted, e_halted);
            chk("mem_we", mem_we, e_we);
            chk("dma_rvalid", dma_rvalid, m_rvalid);
            chk("cpu_in", cpu_in, ram_q);
            chk("dma_rdata", dma_rdata, ram_q);
            if (chk_addr) chk("mem_address", mem_address, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_seq();
        int n = 0;
        bit hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_reset_n) break;
            n++;
            if (!cpu_hold) hold_ok = 1'b0;
        end
        chk("reset_low_cycles", n, RESET_CYCLES);
        chk("reset_hold", hold_ok, 1);
        chk("vector_fetch", mem_address, 16'hFFFC);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit acks [40];
        bit holds [40];
        int idx, f, r1, g, gh, r2, bh, w, hc, total_hc;

        #2 reset = 1'b1;
        armed = 1'b1;
        cpu_address = 16'hFFFC;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_reset_seq();

        // Held DMA request: bursts of DMA_BURST split by RESYNC + CPU_MIN+1 RUN.
        cycles(10);
        dma_req = 1'b1; dma_we = 1'b0; dma_address = 16'h0300;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            acks[i] = dma_ack;
            holds[i] = cpu_hold;
        end
        @(posedge clock); #1 dma_req = 1'b0;
        idx = 0; r1 = 0; g = 0; gh = 0; r2 = 0; bh = 0;
        while (idx < 40 && !acks[idx]) idx++;
        f = idx;
        while (idx < 40 && acks[idx]) begin r1++; bh += int'(holds[idx]); idx++; end
        while (idx < 40 && !acks[idx]) begin g++; gh += int'(holds[idx]); idx++; end
        while (idx < 40 && acks[idx]) begin r2++; idx++; end
        chk("burst_first_ack", f, 1);
        chk("burst1_len", r1, 16);
        chk("burst_hold", bh, 0);
        chk("gap_len", g, 6);
        chk("gap_run_cycles", gh, 5);
        chk("burst2_len", r2, 16);

        // JSR push: DMA waits for the two core writes to finish.
        cycles(8);
        cpu_we = 1'b1; cpu_address = 16'h01FD; cpu_out = 8'h12; dma_req = 1'b1;
        @(negedge clock);
        chk("jsr_ack_w1", dma_ack, 0);
        chk("jsr_we_w1", mem_we, 1);
        @(posedge clock); #1 cpu_address = 16'h01FC; cpu_out = 8'h34;
        @(negedge clock);
        chk("jsr_ack_w2", dma_ack, 0);
        chk("jsr_we_w2", mem_we, 1);
        @(posedge clock); #1 cpu_we = 1'b0; cpu_address = 16'h0400;
        @(negedge clock);
        chk("jsr_ack_read", dma_ack, 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("jsr_ack_grant", dma_ack, 1);
        @(posedge clock); #1 dma_req = 1'b0;
        cycles(2);
        chk("ram_01fd", ram[16'h01FD], 8'h12);
        chk("ram_01fc", ram[16'h01FC], 8'h34);

        // DMA write then read-back of 0x0200.
        cycles(8);
        dma_req = 1'b1; dma_we = 1'b1; dma_address = 16'h0200; dma_wdata = 8'h5A;
        w = 0;
        do begin @(negedge clock); w++; end while (!dma_ack && w < 10);
        chk("wr_ack_seen", dma_ack, 1);
        @(posedge clock); #1 dma_we = 1'b0;
        @(negedge clock);
        chk("rd_ack", dma_ack, 1);
        @(posedge clock); #1 dma_req = 1'b0;
        @(negedge clock);
        chk("rd_rvalid", dma_rvalid, 1);
        chk("rd_data", dma_rdata, 8'h5A);
        chk("ram_0200", ram[16'h0200], 8'h5A);
        cycles(2);

        // Halt, then three single steps.
        halt = 1'b1;
        w = 0;
        do begin @(negedge clock); w++; end while (!halted && w < 10);
        chk("halt_entered", halted, 1);
        total_hc = 0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clock); #1 step = 1'b1;
            @(posedge clock); #1 step = 1'b0;
            @(negedge clock);
            chk("step_resync_halted", halted, 0);
            chk("step_resync_hold", cpu_hold, 0);
            hc = 0;
            repeat (3) begin @(negedge clock); hc += int'(cpu_hold); end
            chk("step_rehalted", halted, 1);
            chk("step_core_cycles", hc, 1);
            total_hc += hc;
        end
        chk("step_total_cycles", total_hc, 3);
        @(posedge clock); #1 halt = 1'b0;
        cycles(8);

        // Async reset in the middle of a DMA write burst.
        dma_req = 1'b1; dma_we = 1'b1; dma_address = 16'h0500; dma_wdata = 8'h77;
        w = 0;
        do begin @(negedge clock); w++; end while (!dma_ack && w < 10);
        chk("pre_reset_ack", dma_ack, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_ack", dma_ack, 0);
        chk("async_we", mem_we, 0);
        chk("async_rstn", cpu_reset_n, 0);
        chk("async_hold", cpu_hold, 1);
        @(posedge clock);
        #1 reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0; cpu_address = 16'hFFFC;
        check_reset_seq();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 699) == 0) reset = 1'b1;
            cpu_address = 16'($urandom);
            cpu_out     = 8'($urandom);
            cpu_we      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) dma_req = !dma_req;
            dma_address = 16'($urandom);
            dma_wdata   = 8'($urandom);
            dma_we      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) halt = !halt;
            step = ($urandom_range(0, 9) == 0);
        end
        reset = 1'b0; halt = 1'b0; dma_req = 1'b0; step = 1'b0;
        cycles(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
Owns the single-port synchronous RAM shared by the 6502 core and one DMA requester (sprite/blit copier, loader). Sequences the core through its `hold` and `reset_n` inputs: reset pulse after power-up, stall during DMA, and debugger halt/single-step. Sits between the core, the RAM and the DMA engine at top level. RAM has 1-cycle read latency: address in cycle k gives data in cycle k+1.

Parameters:
RESET_CYCLES, 4, cycles cpu_reset_n is held low (with cpu_hold=1) after reset.
DMA_BURST, 16, max consecutive DMA grant cycles while CPU is not halted.
CPU_MIN, 4, min RUN cycles between two DMA bursts.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_address  in  16  core address
cpu_out  in  8  core write data
cpu_we  in  1  core write enable
cpu_in  out  8  data to core (= mem_rdata)
cpu_hold  out  1  1 = core advances this cycle
cpu_reset_n  out  1  core reset, active low
mem_address  out  16  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  8  RAM read data
dma_req  in  1  DMA wants the bus (level)
dma_address  in  16  DMA address
dma_wdata  in  8  DMA write data
dma_we  in  1  DMA write
dma_ack  out  1  DMA access performed at this edge
dma_rdata  out  8  DMA read data (= mem_rdata)
dma_rvalid  out  1  dma_rdata valid (read acked previous cycle)
halt  in  1  debugger halt request (level)
step  in  1  single-step pulse, honoured only while halted
halted  out  1  core is stopped by halt

Behaviour:
- States: RST, RUN, DMA, RESYNC, HALT. Outputs are a combinational decode of the registered state. dma_rvalid is registered.
- Reset (async): state=RST, all counters=0, cpu_cnt=CPU_MIN, step_flag=0. Outputs: cpu_hold=1, cpu_reset_n=0, mem_we=0, dma_ack=0, dma_rvalid=0, halted=0.
- RST: cpu_hold=1, cpu_reset_n=0. Move to RUN after RESET_CYCLES cycles.
- RUN: cpu_hold=1. mem_* = cpu_*. cpu_cnt increments, saturating at CPU_MIN.
  - Leave RUN only in a cycle with cpu_we=0, so core writes are never split.
  - Priority: halt=1 -> HALT. Otherwise dma_req=1 and cpu_cnt>=CPU_MIN -> DMA.
  - If step_flag=1: leave to HALT after the first cycle with cpu_we=0, and clear step_flag.
- DMA: cpu_hold=0. mem_* = dma_*. dma_ack=1 every cycle. burst_cnt increments.
  - Exit when dma_req=0, or when burst_cnt reaches DMA_BURST-1 with halt=0.
  - On exit: go to HALT if halt=1, else RESYNC. burst_cnt=0 and cpu_cnt=0 on exit.
- RESYNC: one cycle. cpu_hold=0. mem_address=cpu_address, mem_we=0, so the core's pending read is valid in the next cycle. Then RUN.
- HALT: cpu_hold=0, halted=1, mem_address=cpu_address, mem_we=0. cpu_cnt is ignored here.
  - dma_req -> DMA; no burst limit while halt=1.
  - halt=0 -> RESYNC.
  - step=1 -> RESYNC with step_flag=1.
  - halt=0 and step together: treated as resume; step_flag=0.
- dma_rvalid = previous cycle's (dma_ack & ~dma_we). The requester advances its address/data on each acked edge.
- halt rising during DMA: the burst continues, with no limit, until dma_req drops; then HALT.
- reset asserted mid-DMA: dma_ack and mem_we drop immediately; any in-flight access is lost.
- cpu_in is always mem_rdata; the core ignores it while cpu_hold=0.

Decomposition:
- Shared package `bus_pkg`: state encoding constants (ARB_RST, ARB_RUN, ARB_DMA, ARB_RESYNC, ARB_HALT) and the default parameter values.
- One natural sub-module, `bus_mux`: the combinational address/wdata/we selector between the cpu and dma sources. Counters and the FSM stay in the top module.

Test Plan:
- Reset release -> cpu_reset_n=0 for exactly 4 cycles with cpu_hold=1, then cpu_reset_n=1. The core fetches the vector at FFFC/FFFD.
- dma_req held for 40 cycles while CPU runs; DMA_BURST=16, CPU_MIN=4 -> ack bursts of 16, each followed by 1 RESYNC and then >=4 RUN cycles. Core program result unchanged versus a run without DMA.
- dma_req rises while the core performs a JSR (cpu_we high 2 cycles) -> DMA grant delayed until cpu_we=0. RAM at 01FD/01FC holds the correct return address.
- DMA write 0x5A to 0x0200, then DMA read of 0x0200 -> dma_rvalid=1 one cycle after the read ack, with dma_rdata=0x5A.
- halt=1, then step pulsed 3 times -> halted=1 between steps; each step runs RESYNC plus exactly one non-write core cycle. cpu_address advances accordingly.
- Async reset asserted during a DMA burst -> same-cycle dma_ack=0, mem_we=0, cpu_reset_n=0; the full RST sequence restarts.
